// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, FSM encoding and field helpers
// for the FP datapath (divider now, multiplier later).
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX  = (1 << EXP_W) - 1;
  localparam int ITERS    = MAN_W + 3;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[MAN_W +: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [31:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Exponent field of zero covers denormals too: they are flushed to zero.
  function automatic logic is_zero(input logic [31:0] x);
    return f_exp(x) == '0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&f_exp(x)) && (f_man(x) == '0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (&f_exp(x)) && (f_man(x) != '0);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa with guard/round/sticky,
// plus overflow/underflow detection on the post-rounding exponent.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic                    [MAN_W-1:0] man,
  input  logic signed             [EXP_W+1:0] exp_in,
  input  logic                                guard,
  input  logic                                rnd,
  input  logic                                sticky,
  output logic                    [MAN_W-1:0] man_out,
  output logic                    [EXP_W-1:0] exp_out,
  output logic                                overflow,
  output logic                                underflow
);

  localparam logic signed [EXP_W+1:0] EXP_TOP  = (EXP_W + 2)'(EXP_MAX);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic                    inc;
  logic        [MAN_W:0]   sum;
  logic signed [EXP_W+1:0] exp_adj;

  always_comb begin
    inc       = guard & (rnd | sticky | man[0]);
    sum       = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    // A carry out leaves the low bits at zero, which is the required 1.0 mantissa.
    man_out   = sum[MAN_W-1:0];
    exp_adj   = exp_in + signed'({{(EXP_W + 1){1'b0}}, sum[MAN_W]});
    exp_out   = exp_adj[EXP_W-1:0];
    overflow  = exp_adj >= EXP_TOP;
    underflow = exp_adj <= EXP_ZERO;
  end

endmodule

// File: rtl/float_divider.sv
// Sequential single-precision divider: restoring division, one quotient bit
// per clock, RNE rounding, denormals flushed to zero.
module float_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(EXP_BIAS);
  localparam logic signed [EXP_W+1:0] ONE_S  = (EXP_W + 2)'(1);

  state_t state, state_nxt;

  logic        [31:0]      a_q, b_q;
  logic                    sign_q;
  logic signed [EXP_W+1:0] exp_q;
  logic        [MAN_W+1:0] rem_q;
  logic        [MAN_W:0]   mb_q;
  logic        [MAN_W+2:0] q_q;
  logic        [4:0]       cnt_q;

  logic                    accept;
  logic                    special;
  logic        [31:0]      special_res;
  logic signed [EXP_W+1:0] ea_s, eb_s;
  logic        [MAN_W+1:0] diff;
  logic                    ge;
  logic        [MAN_W-1:0] man_r;
  logic        [EXP_W-1:0] exp_r;
  logic                    ovf, unf;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_UNPACK) || (state == S_DIVIDE) ||
                  (state == S_NORM)   || (state == S_ROUND);
  assign done   = (state == S_DONE);

  assign ea_s = signed'({2'b00, f_exp(a_q)});
  assign eb_s = signed'({2'b00, f_exp(b_q)});
  assign diff = rem_q - {1'b0, mb_q};
  assign ge   = rem_q >= {1'b0, mb_q};

  // Special-operand classification, highest priority first.
  always_comb begin
    special     = 1'b1;
    special_res = QNAN;
    if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) ||
        (is_inf(a_q) && is_inf(b_q)))
      special_res = QNAN;
    else if (is_inf(a_q) || is_zero(b_q))
      special_res = {f_sign(a_q) ^ f_sign(b_q), POS_INF[30:0]};
    else if (is_zero(a_q) || is_inf(b_q))
      special_res = {f_sign(a_q) ^ f_sign(b_q), 31'h0};
    else
      special = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt_q == 5'd1) state_nxt = S_NORM;
      S_NORM:   state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   state_nxt = start ? S_UNPACK : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      quotient <= '0;
    end else begin
      case (state)
        S_UNPACK: begin
          cnt_q <= 5'(ITERS);
          if (special) quotient <= special_res;
        end
        S_DIVIDE: cnt_q <= cnt_q - 5'd1;
        S_ROUND: begin
          if (ovf)      quotient <= {sign_q, POS_INF[30:0]};
          else if (unf) quotient <= {sign_q, 31'h0};
          else          quotient <= {sign_q, exp_r, man_r};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
    case (state)
      S_UNPACK: begin
        sign_q <= f_sign(a_q) ^ f_sign(b_q);
        exp_q  <= ea_s - eb_s + BIAS_S;
        rem_q  <= {2'b01, f_man(a_q)};
        mb_q   <= {1'b1, f_man(b_q)};
        q_q    <= '0;
      end
      S_DIVIDE: begin
        q_q   <= {q_q[MAN_W+1:0], ge};
        rem_q <= ge ? {diff[MAN_W:0], 1'b0} : {rem_q[MAN_W:0], 1'b0};
      end
      // A quotient below 1.0 has its leading one at q[24]; bring it to q[25].
      S_NORM: begin
        if (!q_q[MAN_W+2]) begin
          q_q   <= {q_q[MAN_W+1:0], 1'b0};
          exp_q <= exp_q - ONE_S;
        end
      end
      default: ;
    endcase
  end

  fp_round_rne u_round (
    .man       (q_q[MAN_W+1:2]),
    .exp_in    (exp_q),
    .guard     (q_q[1]),
    .rnd       (q_q[0]),
    .sticky    (|rem_q),
    .man_out   (man_r),
    .exp_out   (exp_r),
    .overflow  (ovf),
    .underflow (unf)
  );

endmodule
